// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state
// encoding, instruction-word field positions and the PC increment.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } fetch_state_t;

   localparam int OPCODE_MSB = 31;
   localparam int RS_MSB     = 25;
   localparam int RT_MSB     = 20;
   localparam int OFFSET_MSB = 15;

   localparam int OPCODE_W = 6;
   localparam int REG_W    = 5;
   localparam int OFFSET_W = 16;
   localparam int JUMP_W   = 26;

   localparam logic [31:0] PC_INCR = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_instr_reg.sv
// Load-enabled 32-bit instruction register with asynchronous reset; exposes
// the opcode, rs, rt, offset and jump-field slices of the held word.
module instr_reg
   import fetch_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [31:0]         d,
   output logic [OPCODE_W-1:0] opcode,
   output logic [REG_W-1:0]    rs,
   output logic [REG_W-1:0]    rt,
   output logic [OFFSET_W-1:0] offset,
   output logic [JUMP_W-1:0]   jump_field
);

   logic [31:0] ir_q;

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_q <= '0;
      end else if (load) begin
         ir_q <= d;
      end
   end

   assign opcode     = ir_q[OPCODE_MSB -: OPCODE_W];
   assign rs         = ir_q[RS_MSB -: REG_W];
   assign rt         = ir_q[RT_MSB -: REG_W];
   assign offset     = ir_q[OFFSET_MSB -: OFFSET_W];
   assign jump_field = ir_q[JUMP_W-1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch block: owns the PC, runs the one-word memory read
// handshake and latches the returned instruction into the IR.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fetch_start,
   input  logic                pc_write,
   input  logic [31:0]         pc_next,
   output logic                mem_rd,
   output logic [31:0]         mem_addr,
   input  logic [31:0]         mem_rdata,
   input  logic                mem_valid,
   output logic                busy,
   output logic                instr_valid,
   output logic [31:0]         pc,
   output logic [31:0]         pc_plus4,
   output logic [OPCODE_W-1:0] opcode,
   output logic [REG_W-1:0]    rs,
   output logic [REG_W-1:0]    rt,
   output logic [OFFSET_W-1:0] offset,
   output logic [JUMP_W-1:0]   jump_field
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pend_pc_q, pend_pc_d;
   logic         pend_valid_q, pend_valid_d;
   logic         fetch_done;

   assign fetch_done = (state_q == WAIT) && mem_valid;
   assign pc_plus4   = pc_q + PC_INCR;
   assign pc         = pc_q;
   assign mem_addr   = word_align(pc_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement leaves a value unassigned and infers a latch.
   always_comb begin
      state_d     = state_q;
      mem_rd      = 1'b0;
      instr_valid = 1'b0;
      busy        = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (fetch_start) state_d = REQ;
         end
         REQ: begin
            mem_rd  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_valid) state_d = DONE;
         end
         DONE: begin
            instr_valid = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A write arriving mid-fetch is parked until completion; a write on the
   // completing edge itself takes priority over anything parked.
   always_comb begin
      pc_d         = pc_q;
      pend_pc_d    = pend_pc_q;
      pend_valid_d = pend_valid_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (pc_write) pc_d = pc_next;
         end
         REQ: begin
            if (pc_write) begin
               pend_pc_d    = pc_next;
               pend_valid_d = 1'b1;
            end
         end
         WAIT: begin
            if (mem_valid) begin
               if (pc_write)          pc_d = pc_next;
               else if (pend_valid_q) pc_d = pend_pc_q;
               else                   pc_d = pc_plus4;
               pend_valid_d = 1'b0;
            end else if (pc_write) begin
               pend_pc_d    = pc_next;
               pend_valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         pend_pc_q    <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         pend_pc_q    <= pend_pc_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   instr_reg u_instr_reg (
      .clk        (clk),
      .reset      (reset),
      .load       (fetch_done),
      .d          (mem_rdata),
      .opcode     (opcode),
      .rs         (rs),
      .rt         (rt),
      .offset     (offset),
      .jump_field (jump_field)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand
// sequences for reset/back-to-back corners, and randomized fetch transactions.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_start;
   logic        pc_write;
   logic [31:0] pc_next;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        busy;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [15:0] offset;
   logic [25:0] jump_field;

   int checks   = 0;
   int failures = 0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_start (fetch_start),
      .pc_write    (pc_write),
      .pc_next     (pc_next),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_valid   (mem_valid),
      .busy        (busy),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .opcode      (opcode),
      .rs          (rs),
      .rt          (rt),
      .offset      (offset),
      .jump_field  (jump_field)
   );

   always #5 clk = ~clk;

   // One fetch transaction: pc loaded in IDLE, memory latency in WAIT cycles,
   // up to two pc_write events (position 0 = REQ cycle, 1..lat = WAIT cycles,
   // lat = the completing edge), and the expected outcome.
   typedef struct {
      logic [31:0] pc_init;
      logic [31:0] word;
      int          lat;
      int          wa_pos;
      logic [31:0] wa_val;
      int          wb_pos;
      logic [31:0] wb_val;
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
      logic [5:0]  exp_op;
      logic [4:0]  exp_rs;
      logic [4:0]  exp_rt;
      logic [15:0] exp_off;
      logic [25:0] exp_jf;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] model_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pc(input logic [31:0] v);
      pc_write = 1'b1;
      pc_next  = v;
      tick();
      pc_write = 1'b0;
      pc_next  = $urandom;
      check("idle_pc_write", pc, v);
      model_pc = v;
   endtask

   task automatic drive_write(input vec_t v, input int pos);
      pc_write = 1'b0;
      pc_next  = $urandom;
      if (v.wa_pos == pos) begin
         pc_write = 1'b1;
         pc_next  = v.wa_val;
      end else if (v.wb_pos == pos) begin
         pc_write = 1'b1;
         pc_next  = v.wb_val;
      end
   endtask

   task automatic run_fetch(input vec_t v, input bit noise);
      load_pc(v.pc_init);
      fetch_start = 1'b1;
      tick();
      fetch_start = noise;
      check("req_mem_rd", mem_rd, 1);
      check("req_addr", mem_addr, v.exp_addr);
      check("req_busy", busy, 1);
      check("req_iv", instr_valid, 0);
      check("req_pc", pc, v.pc_init);
      check("req_pc_plus4", pc_plus4, v.pc_init + 32'd4);
      drive_write(v, 0);
      mem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
      tick();
      for (int j = 1; j <= v.lat; j++) begin
         check("wait_mem_rd", mem_rd, 0);
         check("wait_busy", busy, 1);
         check("wait_iv", instr_valid, 0);
         check("wait_pc", pc, v.pc_init);
         drive_write(v, j);
         mem_valid = (j == v.lat);
         mem_rdata = (j == v.lat) ? v.word : $urandom;
         tick();
      end
      pc_write    = 1'b0;
      mem_valid   = noise;
      mem_rdata   = $urandom;
      fetch_start = noise;
      check("done_iv", instr_valid, 1);
      check("done_busy", busy, 1);
      check("done_mem_rd", mem_rd, 0);
      check("done_pc", pc, v.exp_pc);
      check("done_opcode", opcode, v.exp_op);
      check("done_rs", rs, v.exp_rs);
      check("done_rt", rt, v.exp_rt);
      check("done_offset", offset, v.exp_off);
      check("done_jump", jump_field, v.exp_jf);
      tick();
      mem_valid   = 1'b0;
      fetch_start = 1'b0;
      check("idle_iv", instr_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_pc_hold", pc, v.exp_pc);
      check("idle_ir_hold", jump_field, v.exp_jf);
      model_pc = v.exp_pc;
   endtask

   // Reference outcome of a fetch from the rules: the chronologically last
   // pc_write of the transaction wins, otherwise pc advances by 4 (mod 2^32).
   function automatic vec_t make_expect(input vec_t v);
      vec_t r = v;
      int   best = -1;
      r.exp_pc = v.pc_init + 32'd4;
      if (v.wa_pos >= 0 && v.wa_pos > best) begin best = v.wa_pos; r.exp_pc = v.wa_val; end
      if (v.wb_pos >= 0 && v.wb_pos > best) begin best = v.wb_pos; r.exp_pc = v.wb_val; end
      r.exp_addr = v.pc_init - (v.pc_init % 32'd4);
      r.exp_op   = v.word[31:26];
      r.exp_rs   = v.word[25:21];
      r.exp_rt   = v.word[20:16];
      r.exp_off  = v.word[15:0];
      r.exp_jf   = v.word[25:0];
      return r;
   endfunction

   initial begin
      vec_t r;
      logic prev_rd;

      //         pc_init        word           lat wa  wa_val         wb  wb_val         addr           pc             op     rs     rt     off       jf
      vecs[0] = '{32'h0000_0000, 32'h0822_0010, 1, -1, 32'h0,         -1, 32'h0,         32'h0000_0000, 32'h0000_0004, 6'h02, 5'h01, 5'h02, 16'h0010, 26'h022_0010};
      vecs[1] = '{32'h0000_0004, 32'h8C43_FFFC, 5, -1, 32'h0,         -1, 32'h0,         32'h0000_0004, 32'h0000_0008, 6'h23, 5'h02, 5'h03, 16'hFFFC, 26'h043_FFFC};
      vecs[2] = '{32'h0000_0008, 32'h1000_0000, 3,  2, 32'h0040_0100, -1, 32'h0,         32'h0000_0008, 32'h0040_0100, 6'h04, 5'h00, 5'h00, 16'h0000, 26'h000_0000};
      vecs[3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 1, -1, 32'h0,         -1, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 6'h3F, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FF_FFFF};
      vecs[4] = '{32'h0000_0013, 32'h0000_0000, 2, -1, 32'h0,         -1, 32'h0,         32'h0000_0010, 32'h0000_0017, 6'h00, 5'h00, 5'h00, 16'h0000, 26'h000_0000};
      vecs[5] = '{32'h0000_0100, 32'h2000_1234, 1,  0, 32'h0000_0200, -1, 32'h0,         32'h0000_0100, 32'h0000_0200, 6'h08, 5'h00, 5'h00, 16'h1234, 26'h000_1234};
      vecs[6] = '{32'h0000_0040, 32'h0C00_0040, 2,  1, 32'h0000_0280,  2, 32'h0000_0300, 32'h0000_0040, 32'h0000_0300, 6'h03, 5'h00, 5'h00, 16'h0040, 26'h000_0040};
      vecs[7] = '{32'h0000_1000, 32'hAC22_0008, 4,  1, 32'h0000_2000, -1, 32'h0,         32'h0000_1000, 32'h0000_2000, 6'h2B, 5'h01, 5'h02, 16'h0008, 26'h022_0008};

      reset       = 1'b1;
      fetch_start = 1'b0;
      pc_write    = 1'b0;
      pc_next     = '0;
      mem_rdata   = '0;
      mem_valid   = 1'b0;
      model_pc    = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_iv", instr_valid, 0);
      check("rst_pc", pc, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h4);
      check("rst_opcode", opcode, 0);
      check("rst_jump", jump_field, 0);
      tick();
      reset = 1'b0;

      // Reset mid-WAIT with a pending write, then a stray mem_valid in IDLE.
      load_pc(32'h0000_0008);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      pc_write    = 1'b1;
      pc_next     = 32'h1234_5670;
      tick();
      pc_write = 1'b0;
      check("midwait_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_mem_rd", mem_rd, 0);
      check("abort_iv", instr_valid, 0);
      check("abort_pc", pc, 32'h0);
      check("abort_offset", offset, 0);
      tick();
      reset     = 1'b0;
      mem_valid = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      for (int c = 0; c < 2; c++) begin
         tick();
         check("late_valid_iv", instr_valid, 0);
         check("late_valid_busy", busy, 0);
         check("late_valid_ir", jump_field, 0);
         check("late_valid_pc", pc, 32'h0);
      end
      mem_valid = 1'b0;
      model_pc  = 32'h0;
      // The aborted pending write must not leak into the next fetch.
      r = '{32'h0, 32'h0822_0010, 1, -1, 32'h0, -1, 32'h0, 32'h0, 32'h4, 6'h02, 5'h01, 5'h02, 16'h0010, 26'h022_0010};
      run_fetch(r, 1'b0);

      for (int i = 0; i < 8; i++) run_fetch(vecs[i], 1'b0);

      // fetch_start held high with a one-cycle memory: one fetch every 4 cycles.
      load_pc(32'h0);
      fetch_start = 1'b1;
      prev_rd     = 1'b0;
      for (int c = 0; c < 16; c++) begin
         tick();
         mem_valid = prev_rd;
         mem_rdata = 32'h0;
         if (c == 12) fetch_start = 1'b0;
         check("b2b_mem_rd", mem_rd, (c % 4 == 0) && (c < 13));
         check("b2b_iv", instr_valid, (c % 4 == 2));
         if (mem_rd) check("b2b_addr", mem_addr, 4 * (c / 4));
         if (instr_valid) check("b2b_pc", pc, 4 * (c / 4) + 4);
         prev_rd = mem_rd;
      end
      mem_valid = 1'b0;
      model_pc  = 32'h10;

      for (int i = 0; i < 40; i++) begin
         r.pc_init = ($urandom_range(0, 1) == 0) ? model_pc :
                     ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
         r.word    = $urandom;
         r.lat     = $urandom_range(1, 6);
         r.wa_pos  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, r.lat) : -1;
         r.wa_val  = $urandom;
         r.wb_pos  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, r.lat) : -1;
         r.wb_val  = $urandom;
         if (r.wb_pos == r.wa_pos) r.wb_pos = -1;
         r = make_expect(r);
         run_fetch(r, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multicycle-datapath fetch block. It owns the program counter and runs the memory read handshake for each instruction. It latches the returned word into the instruction register and splits it into opcode, rs, rt, offset and 26-bit jump field for the downstream jump-address and sign-extend logic. New PC values from the PC-source mux, such as jump targets, enter through `pc_write`/`pc_next`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `fetch_start`  in  1  control unit requests the next instruction; sampled only in IDLE.
- `pc_write`  in  1  load `pc_next` into PC.
- `pc_next`  in  32  new PC value from the PC-source mux.
- `mem_rd`  out  1  memory read strobe, one cycle wide.
- `mem_addr`  out  32  word-aligned fetch address, `{pc[31:2],2'b00}`.
- `mem_rdata`  in  32  instruction word from memory.
- `mem_valid`  in  1  `mem_rdata` is valid; sampled only in WAIT.
- `busy`  out  1  high in REQ, WAIT and DONE.
- `instr_valid`  out  1  one-cycle pulse: IR fields are fresh.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4`, combinational; wraps modulo 2^32.
- `opcode`  out  6  IR[31:26].
- `rs`  out  5  IR[25:21].
- `rt`  out  5  IR[20:16].
- `offset`  out  16  IR[15:0].
- `jump_field`  out  26  IR[25:0].

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. State encoding is a registered enum.
- IDLE with `fetch_start`=1: go to REQ. Otherwise stay in IDLE.
- REQ: `mem_rd`=1 and `mem_addr` driven from PC. Go to WAIT unconditionally.
- WAIT with `mem_valid`=1: load IR from `mem_rdata`, update PC, go to DONE. Otherwise stay in WAIT. There is no timeout.
- DONE: `instr_valid`=1. Go to IDLE.
- PC update at fetch completion:
  - If a pending write exists, or `pc_write` is high in the completing cycle, PC takes that value.
  - Otherwise PC takes `pc + 4`.
  - When both are present, the new `pc_write` beats the pending value.
- `pc_write` in IDLE or DONE: PC loads `pc_next` at that edge.
- `pc_write` in REQ or WAIT (not the completing edge): `pc_next` is captured into a pending register and a pending flag is set. A later write overwrites the pending value. The flag clears when the fetch completes.
- `fetch_start` in any state other than IDLE is ignored; no queueing.
- IR fields hold their value until the next completed fetch.
- The PC low two bits are stored as written. Only `mem_addr` is forced aligned.
- `mem_rd` and `instr_valid` are decoded from state and are glitch-free (registered state).

## Timing
- Reset values, applied immediately on `reset` assertion:
  - state = IDLE.
  - `pc` = `RESET_PC`.
  - IR = 0, so all field outputs are 0.
  - pending flag = 0.
  - `mem_rd` = 0, `instr_valid` = 0, `busy` = 0.
- Reset during REQ, WAIT or DONE aborts the fetch. A `mem_valid` arriving after reset deasserts, while in IDLE, is ignored.
- Latency, with `fetch_start` sampled at edge k:
  - `mem_rd` high during cycle k→k+1.
  - WAIT from edge k+1.
  - If `mem_valid` is sampled at edge k+1+n (n≥1 cycles in WAIT), `instr_valid` is high for the cycle after edge k+1+n.
  - Minimum `fetch_start`→`instr_valid` is 3 edges.
- Back-to-back fetches: `fetch_start` held high yields one fetch every 4 cycles when memory answers in 1 cycle.
- `mem_valid` during IDLE, REQ or DONE has no effect.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {IDLE, REQ, WAIT, DONE}.
  - field-position constants (OPCODE_MSB=31, RS_MSB=25, RT_MSB=20, OFFSET_MSB=15).
  - `PC_INCR` = 4.
- One sub-module, `instr_reg`: 32-bit load-enabled register with async reset that exposes the five field slices.
- FSM, PC register, pending register and increment logic live in `instr_fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0; pulse `fetch_start`; `mem_valid` one cycle into WAIT with `mem_rdata`=32'h0822_0010 → `mem_addr`=0 during REQ; `instr_valid` 3 edges after start; `opcode`=2, `rs`=1, `rt`=2, `offset`=16'h0010, `jump_field`=26'h022_0010, `pc`=4.
- `mem_valid` delayed 5 cycles → `busy` stays high, `mem_rd` is a single cycle, `instr_valid` lands exactly 1 cycle after the `mem_valid` edge.
- `pc_write` with `pc_next`=32'h0040_0100 during WAIT, then completion → `pc`=32'h0040_0100, not old `pc`+4; pending flag clear afterwards.
- `pc`=32'hFFFF_FFFC, one fetch → `pc`=0 (wrap); `pc_next`=32'h0000_0013 → `mem_addr`=32'h0000_0010.
- Assert `reset` mid-WAIT with `pc`=8, then a late `mem_valid` → outputs at reset values, IR unchanged at 0, no `instr_valid`.
- `fetch_start` held high, 1-cycle memory → `instr_valid` every 4 cycles, PC advancing 0, 4, 8.
